fetch_unit: RTL and testbench

- Instruction-fetch stage that drives the IF/ID pipeline register's write side: instruction word, PC+4, write enable and flush (bubble).
- Owns the PC and a request/acknowledge handshake to instruction memory.
- Holds one fetched instruction in a buffer until IF/ID accepts it.
- Handles branch/jump redirects from later stages, including redirects that arrive while a memory request is still outstanding.

---
 rtl/fetch_unit_if.sv | 13 +
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bundle for the fetch stage.
// master: fetch unit (drives request/address); slave: instruction memory.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ack, input  imem_rdata);
  modport slave  (input  imem_req, input  imem_addr,
                  output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage driving the write side of the IF/ID register.
// Owns the PC, runs a req/ack handshake with instruction memory, and keeps
// one fetched instruction in a buffer until IF/ID takes it. Redirects that
// land while a request is outstanding park the FSM in DROP until the stale
// ack returns.
// Optional: define FETCH_STATS_EN to add the saturating o_bubble_cnt output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,          // asynchronous, active-low
  input  logic               stall_in,
  input  logic               redirect,
  input  logic        [31:0] redirect_pc,
  fetch_unit_if.master       imem,
  output logic        [31:0] o_com,
  output logic        [31:0] o_pc_plus4,
  output logic               o_write,
  output logic               o_flush
`ifdef FETCH_STATS_EN
  ,
  output logic        [31:0] o_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] addr_q;       // address of the outstanding request
  logic        buf_valid_q;
  logic [31:0] buf_com_q;
  logic [31:0] buf_pc4_q;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic        consume;
  logic        req_c;
  logic        issue;
  logic        fill;

  assign pc_plus4     = pc_q + 32'd4;  // wraps mod 2^32
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign consume      = buf_valid_q & ~stall_in & ~redirect;

  // While reset is held the IF/ID side sees a bubble and memory sees no request.
  assign o_write        = rst & ~stall_in;
  assign o_flush        = ~rst | redirect | (~buf_valid_q & ~stall_in);
  assign o_com          = buf_com_q;
  assign o_pc_plus4     = buf_pc4_q;
  assign imem.imem_req  = rst & req_c;
  assign imem.imem_addr = (state_q == IDLE) ? pc_q : addr_q;

  // Next-state and request decode; a redirect in IDLE suppresses the request
  // so the new target is fetched in the following cycle.
  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    issue   = 1'b0;
    fill    = 1'b0;
    case (state_q)
      IDLE: begin
        if (~redirect & (~buf_valid_q | consume)) begin
          req_c   = 1'b1;
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (imem.imem_ack) begin
          state_d = IDLE;
          fill    = ~redirect;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        req_c = 1'b1;
        if (imem.imem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // PC and latched request address; redirect wins over a completing fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      if (redirect) begin
        pc_q <= redirect_tgt;
      end else if (fill) begin
        pc_q <= pc_plus4;
      end
      if (issue) begin
        addr_q <= pc_q;
      end
    end
  end

  // Single-entry instruction buffer feeding IF/ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_com_q   <= 32'h0;
      buf_pc4_q   <= 32'h0;
    end else begin
      if (redirect) begin
        buf_valid_q <= 1'b0;
      end else if (fill) begin
        buf_valid_q <= 1'b1;
        buf_com_q   <= imem.imem_rdata;
        buf_pc4_q   <= pc_plus4;
      end else if (consume) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

`ifdef FETCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] bubble_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;

  // Count bubble cycles presented to IF/ID, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= 32'h0;
    end else if (o_flush) begin
      bubble_cnt_q <= sat_inc(bubble_cnt_q);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: nominal fetch, stall hold, redirect while
// waiting, redirect with same-cycle ack, async reset mid-request and PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] o_com, o_pc_plus4;
  logic        o_write, o_flush;

  logic        rstb_n = 1'b0;
  logic [31:0] o_com_b, o_pc_plus4_b;
  logic        o_write_b, o_flush_b;

  int n_chk = 0;
  int n_fail = 0;

  fetch_unit_if imem_a ();
  fetch_unit_if imem_b ();

`ifdef FETCH_STATS_EN
  logic [31:0] bubble_cnt_a, bubble_cnt_b;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk         (clk),
    .rst         (rst_n),
    .stall_in    (stall_in),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_a),
    .o_com       (o_com),
    .o_pc_plus4  (o_pc_plus4),
    .o_write     (o_write),
    .o_flush     (o_flush)
`ifdef FETCH_STATS_EN
    ,
    .o_bubble_cnt(bubble_cnt_a)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk         (clk),
    .rst         (rstb_n),
    .stall_in    (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .imem        (imem_b),
    .o_com       (o_com_b),
    .o_pc_plus4  (o_pc_plus4_b),
    .o_write     (o_write_b),
    .o_flush     (o_flush_b)
`ifdef FETCH_STATS_EN
    ,
    .o_bubble_cnt(bubble_cnt_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    imem_a.imem_ack   = 1'b0;
    imem_a.imem_rdata = 32'h0;
    imem_b.imem_ack   = 1'b0;
    imem_b.imem_rdata = 32'h0;

    // reset values
    #2;
    chk("rst_req",   {31'b0, imem_a.imem_req}, 32'd0);
    chk("rst_addr",  imem_a.imem_addr, 32'h0);
    chk("rst_com",   o_com, 32'h0);
    chk("rst_pc4",   o_pc_plus4, 32'h0);
    chk("rst_flush", {31'b0, o_flush}, 32'd1);
    chk("rst_write", {31'b0, o_write}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // nominal fetch, 1-cycle memory
    chk("c0_req",   {31'b0, imem_a.imem_req}, 32'd1);
    chk("c0_addr",  imem_a.imem_addr, 32'h0);
    chk("c0_flush", {31'b0, o_flush}, 32'd1);
    chk("c0_write", {31'b0, o_write}, 32'd1);
    cyc(); imem_a.imem_ack = 1'b1; imem_a.imem_rdata = 32'h2010_0001; #1;
    chk("c1_req",   {31'b0, imem_a.imem_req}, 32'd1);
    chk("c1_addr",  imem_a.imem_addr, 32'h0);
    chk("c1_flush", {31'b0, o_flush}, 32'd1);
    cyc(); imem_a.imem_ack = 1'b0; #1;
    chk("c2_com",   o_com, 32'h2010_0001);
    chk("c2_pc4",   o_pc_plus4, 32'h4);
    chk("c2_flush", {31'b0, o_flush}, 32'd0);
    chk("c2_req",   {31'b0, imem_a.imem_req}, 32'd1);
    chk("c2_addr",  imem_a.imem_addr, 32'h4);
    cyc(); imem_a.imem_ack = 1'b1; imem_a.imem_rdata = 32'h2010_0002; #1;
    chk("c3_flush", {31'b0, o_flush}, 32'd1);
    chk("c3_addr",  imem_a.imem_addr, 32'h4);
    cyc(); imem_a.imem_ack = 1'b0; #1;
    chk("c4_com",   o_com, 32'h2010_0002);
    chk("c4_pc4",   o_pc_plus4, 32'h8);
    chk("c4_flush", {31'b0, o_flush}, 32'd0);
    chk("c4_addr",  imem_a.imem_addr, 32'h8);
    cyc(); imem_a.imem_ack = 1'b1; imem_a.imem_rdata = 32'hAAAA_0000; #1;
    chk("c5_addr",  imem_a.imem_addr, 32'h8);

    // stall with a full buffer
    cyc(); imem_a.imem_ack = 1'b0; stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stl_write", {31'b0, o_write}, 32'd0);
      chk("stl_com",   o_com, 32'hAAAA_0000);
      chk("stl_req",   {31'b0, imem_a.imem_req}, 32'd0);
      chk("stl_flush", {31'b0, o_flush}, 32'd0);
      cyc();
    end
    stall_in = 1'b0; #1;
    chk("rel_flush", {31'b0, o_flush}, 32'd0);
    chk("rel_write", {31'b0, o_write}, 32'd1);
    chk("rel_req",   {31'b0, imem_a.imem_req}, 32'd1);
    chk("rel_addr",  imem_a.imem_addr, 32'hC);

    // redirect while waiting on 0xC; ack arrives 3 cycles later
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("rd_flush", {31'b0, o_flush}, 32'd1);
    chk("rd_addr",  imem_a.imem_addr, 32'hC);
    cyc(); redirect = 1'b0; #1;
    chk("drop_req",   {31'b0, imem_a.imem_req}, 32'd1);
    chk("drop_addr",  imem_a.imem_addr, 32'hC);
    chk("drop_flush", {31'b0, o_flush}, 32'd1);
    cyc(); #1;
    chk("drop_addr2", imem_a.imem_addr, 32'hC);
    cyc(); imem_a.imem_ack = 1'b1; imem_a.imem_rdata = 32'hDEAD_BEEF; #1;
    chk("drop_ack_addr", imem_a.imem_addr, 32'hC);
    cyc(); imem_a.imem_ack = 1'b0; #1;
    chk("new_addr",  imem_a.imem_addr, 32'h100);
    chk("new_req",   {31'b0, imem_a.imem_req}, 32'd1);
    chk("new_flush", {31'b0, o_flush}, 32'd1);
    cyc(); imem_a.imem_ack = 1'b1; imem_a.imem_rdata = 32'h1234_5678; #1;
    chk("new_flush2", {31'b0, o_flush}, 32'd1);
    cyc(); imem_a.imem_ack = 1'b0; stall_in = 1'b1; #1;
    chk("new_com",  o_com, 32'h1234_5678);
    chk("new_pc4",  o_pc_plus4, 32'h104);
    chk("full_req", {31'b0, imem_a.imem_req}, 32'd0);

    // redirect + ack together, buffer full, stalled
    cyc(); redirect = 1'b1; redirect_pc = 32'h200;
    imem_a.imem_ack = 1'b1; imem_a.imem_rdata = 32'h0BAD_0BAD; #1;
    chk("rda_flush", {31'b0, o_flush}, 32'd1);
    chk("rda_write", {31'b0, o_write}, 32'd0);
    chk("rda_req",   {31'b0, imem_a.imem_req}, 32'd0);
    cyc(); redirect = 1'b0; imem_a.imem_ack = 1'b0; stall_in = 1'b0; #1;
    chk("rda_clr_flush", {31'b0, o_flush}, 32'd1);
    chk("rda_pc_addr",   imem_a.imem_addr, 32'h200);
    chk("rda_req2",      {31'b0, imem_a.imem_req}, 32'd1);

    // async reset while waiting on 0x200
    cyc(); rst_n = 1'b0; #1;
    chk("mr_req",   {31'b0, imem_a.imem_req}, 32'd0);
    chk("mr_addr",  imem_a.imem_addr, 32'h0);
    chk("mr_com",   o_com, 32'h0);
    chk("mr_pc4",   o_pc_plus4, 32'h0);
    chk("mr_flush", {31'b0, o_flush}, 32'd1);
    chk("mr_write", {31'b0, o_write}, 32'd0);
    cyc(); rst_n = 1'b1; imem_a.imem_ack = 1'b1; imem_a.imem_rdata = 32'hFFFF_FFFF; #1;
    chk("mr_rel_req",  {31'b0, imem_a.imem_req}, 32'd1);
    chk("mr_rel_addr", imem_a.imem_addr, 32'h0);
    cyc(); imem_a.imem_ack = 1'b0; #1;
    chk("mr_ign_flush", {31'b0, o_flush}, 32'd1);
    chk("mr_ign_addr",  imem_a.imem_addr, 32'h0);

    // redirect + ack together while waiting: back to IDLE, not DROP
    redirect = 1'b1; redirect_pc = 32'h40;
    imem_a.imem_ack = 1'b1; imem_a.imem_rdata = 32'h5555_5555; #1;
    chk("wra_flush", {31'b0, o_flush}, 32'd1);
    cyc(); redirect = 1'b0; imem_a.imem_ack = 1'b0; #1;
    chk("wra_addr",  imem_a.imem_addr, 32'h40);
    chk("wra_req",   {31'b0, imem_a.imem_req}, 32'd1);
    chk("wra_flush2", {31'b0, o_flush}, 32'd1);
    cyc(); imem_a.imem_ack = 1'b1; imem_a.imem_rdata = 32'h7777_0040; #1;
    cyc(); imem_a.imem_ack = 1'b0; #1;
    chk("wra_com", o_com, 32'h7777_0040);
    chk("wra_pc4", o_pc_plus4, 32'h44);

    // RESET_PC at the top of the address space
    rstb_n = 1'b1; #1;
    chk("wr_addr0", imem_b.imem_addr, 32'hFFFF_FFFC);
    chk("wr_req0",  {31'b0, imem_b.imem_req}, 32'd1);
    for (int i = 0; i < 5; i++) cyc();
`ifdef FETCH_STATS_EN
    chk("bubble_cnt", bubble_cnt_b, 32'd5);
`endif
    chk("wr_wait_addr", imem_b.imem_addr, 32'hFFFF_FFFC);
    imem_b.imem_ack = 1'b1; imem_b.imem_rdata = 32'hCAFE_0000;
    cyc(); imem_b.imem_ack = 1'b0; #1;
    chk("wr_com",   o_com_b, 32'hCAFE_0000);
    chk("wr_pc4",   o_pc_plus4_b, 32'h0);
    chk("wr_addr1", imem_b.imem_addr, 32'h0);
    chk("wr_req1",  {31'b0, imem_b.imem_req}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
